// File: rtl/counter_scheduler_if.sv
// Request/counter bundle for counter_scheduler.
// slave is the scheduler side, master is the requester/counter side.
interface counter_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_d;
    logic [WIDTH-1:0]      cnt_q;
    logic                  cnt_en;
    logic                  cnt_load;
    logic [WIDTH-1:0]      cnt_d;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;

    modport master (
        output req, req_d, cnt_q,
        input  cnt_en, cnt_load, cnt_d, gnt, done, busy
    );

    modport slave (
        input  req, req_d, cnt_q,
        output cnt_en, cnt_load, cnt_d, gnt, done, busy
    );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin sharing of one external up-counter among NREQ requesters.
// Winner's start value is loaded, counted up to all-ones, then done pulses.
module counter_scheduler #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_scheduler_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_last;
    logic [WIDTH-1:0] r_cnt_d;
    logic             r_load;
    logic             r_run;
    logic             r_busy;

    logic             w_any;
    logic [IW-1:0]    w_idx;
    logic [WIDTH-1:0] w_val;
    logic             w_hold;
    logic             w_at_max;
    int               w_dist;
    int               w_best;

    // Distance 0 is the requester just after the last one served.
    always_comb begin
        w_any  = 1'b0;
        w_idx  = '0;
        w_val  = '0;
        w_best = NREQ;
        w_dist = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j + NREQ - 1 - int'(r_last)) % NREQ;
            if (bus.req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_any  = 1'b1;
                w_idx  = IW'(j);
                w_val  = bus.req_d[j*WIDTH +: WIDTH];
            end
        end
    end

    assign w_hold   = |(bus.req & r_gnt);
    assign w_at_max = (bus.cnt_q == MAX);

    // Enable is gated by the live count so the counter never wraps.
    assign bus.cnt_en   = r_run & ~w_at_max;
    assign bus.cnt_load = r_load;
    assign bus.cnt_d    = r_cnt_d;
    assign bus.gnt      = r_gnt;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_idx   <= '0;
            r_last  <= IW'(NREQ - 1);
            r_cnt_d <= '0;
            r_load  <= 1'b0;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_LOAD;
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_idx;
                        r_idx   <= w_idx;
                        r_cnt_d <= w_val;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_load  <= 1'b0;
                    r_cnt_d <= '0;
                    if (w_hold) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_idx;
                    end
                end
                S_RUN: begin
                    if (!w_hold) begin
                        r_state <= S_IDLE;
                        r_run   <= 1'b0;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_idx;
                    end else if (w_at_max) begin
                        r_state <= S_DONE;
                        r_run   <= 1'b0;
                        r_done  <= r_gnt;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_last  <= r_idx;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: directed scenarios plus random traffic,
// checked every cycle against a grant-age model of the schedule.
module tb_counter_scheduler;
    localparam int NREQ  = 2;
    localparam int WIDTH = 4;
    localparam int MAX   = (1 << WIDTH) - 1;

    logic clk;
    logic rst_n;
    logic [WIDTH-1:0] cq;

    int n_tests;
    int n_fail;

    counter_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bif();

    counter_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External counter: shared reset, load beats enable.
    always @(posedge clk) begin
        if (!rst_n)
            cq <= '0;
        else if (bif.cnt_load)
            cq <= bif.cnt_d;
        else if (bif.cnt_en)
            cq <= cq + 1'b1;
    end
    assign bif.cnt_q = cq;

    // Model: owner and age (cycles since the grant edge) fix every output.
    int m_own;
    int m_age;
    int m_val;
    int m_last;
    bit m_ok;

    initial begin
        m_own  = -1;
        m_age  = 0;
        m_val  = 0;
        m_last = NREQ - 1;
        m_ok   = 0;
    end

    always @(posedge clk) begin
        int dc;
        int p;
        if (!rst_n) begin
            m_own  = -1;
            m_last = NREQ - 1;
            m_ok   = 1;
        end else if (m_own < 0) begin
            p = -1;
            for (int k = 1; k <= NREQ; k++)
                if (p < 0 && bif.req[(m_last + k) % NREQ])
                    p = (m_last + k) % NREQ;
            if (p >= 0) begin
                m_own = p;
                m_age = 1;
                m_val = int'(bif.req_d[p*WIDTH +: WIDTH]);
            end
        end else begin
            dc = 3 + MAX - m_val;
            if (m_age == dc || !bif.req[m_own]) begin
                m_last = m_own;
                m_own  = -1;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0]  e_gnt, e_done;
        logic             e_en, e_load, e_busy;
        logic [WIDTH-1:0] e_d;
        int dc;
        if (m_ok) begin
            e_gnt  = '0;
            e_done = '0;
            e_en   = 1'b0;
            e_load = 1'b0;
            e_busy = 1'b0;
            e_d    = '0;
            if (m_own >= 0) begin
                dc     = 3 + MAX - m_val;
                e_busy = 1'b1;
                e_gnt  = NREQ'(1) << m_own;
                e_load = (m_age == 1);
                e_d    = (m_age == 1) ? WIDTH'(m_val) : '0;
                e_en   = (m_age >= 2) && (m_age <= dc - 2);
                e_done = (m_age == dc) ? e_gnt : '0;
            end
            n_tests++;
            if ({bif.busy, bif.gnt, bif.done, bif.cnt_en, bif.cnt_load, bif.cnt_d}
                !== {e_busy, e_gnt, e_done, e_en, e_load, e_d}) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t busy=%b/%b gnt=%b/%b done=%b/%b en=%b/%b load=%b/%b d=%h/%h (got/exp)",
                         $time, bif.busy, e_busy, bif.gnt, e_gnt, bif.done, e_done,
                         bif.cnt_en, e_en, bif.cnt_load, e_load, bif.cnt_d, e_d);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n_en;
        int b;
        n_tests = 0;
        n_fail  = 0;

        // Reset with both requests pending
        rst_n     = 1'b0;
        bif.req   = 2'b11;
        bif.req_d = '0;
        tick(2);
        chk("t1_rst", {bif.gnt, bif.done, bif.cnt_en, bif.cnt_load, bif.busy}, 32'h0);

        // Single request, start C
        rst_n     = 1'b1;
        bif.req   = 2'b01;
        bif.req_d = 8'h0C;
        n_en      = 0;
        tick(1);
        chk("t2_load", {bif.cnt_load, bif.cnt_en, bif.cnt_d}, {26'd0, 2'b10, 4'hC});
        chk("t2_gnt", bif.gnt, 32'h1);
        for (int c = 2; c <= 5; c++) begin
            tick(1);
            n_en += int'(bif.cnt_en);
        end
        chk("t2_en_cycles", n_en, 32'd3);
        chk("t2_count_f", cq, 32'hF);
        tick(1);
        chk("t2_done", bif.done, 32'h1);
        bif.req = 2'b00;
        tick(1);
        chk("t2_gnt_clr", bif.gnt, 32'h0);

        // Two simultaneous requests, round-robin order
        rst_n   = 1'b0;
        tick(2);
        rst_n     = 1'b1;
        bif.req   = 2'b11;
        bif.req_d = {4'hD, 4'hE};
        tick(4);
        chk("t3_done0", bif.done, 32'h1);
        tick(2);
        chk("t3_gnt1", bif.gnt, 32'h2);
        tick(4);
        chk("t3_done1", bif.done, 32'h2);
        tick(2);
        chk("t3_gnt0", bif.gnt, 32'h1);
        bif.req = 2'b00;
        tick(3);

        // Start value already at MAX
        rst_n = 1'b0;
        tick(2);
        rst_n     = 1'b1;
        bif.req   = 2'b10;
        bif.req_d = {4'hF, 4'h0};
        n_en      = 0;
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            n_en += int'(bif.cnt_en);
        end
        chk("t4_done", bif.done, 32'h2);
        chk("t4_no_en", n_en, 32'd0);
        chk("t4_count", cq, 32'hF);
        bif.req = 2'b00;
        tick(2);

        // Abandon in the third RUN cycle with req[1] pending
        rst_n = 1'b0;
        tick(2);
        rst_n     = 1'b1;
        bif.req   = 2'b01;
        bif.req_d = '0;
        tick(2);
        bif.req = 2'b11;
        tick(2);
        bif.req = 2'b10;
        tick(1);
        chk("t5_abandon", {bif.gnt, bif.done, bif.cnt_en, bif.busy}, 32'h0);
        tick(1);
        chk("t5_gnt1", bif.gnt, 32'h2);

        // Reset for one edge mid-RUN
        tick(2);
        chk("t6_busy", bif.busy, 32'h1);
        rst_n   = 1'b0;
        bif.req = 2'b11;
        tick(1);
        chk("t6_rst", {bif.gnt, bif.done, bif.cnt_en, bif.cnt_load, bif.cnt_d, bif.busy}, 32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("t6_gnt0", bif.gnt, 32'h1);

        // Random traffic
        repeat (4000) begin
            if ($urandom_range(0, 11) == 0) begin
                b = int'($urandom_range(0, NREQ - 1));
                bif.req[b] = ~bif.req[b];
            end
            bif.req_d = NREQ*WIDTH'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
